tile_fetch_8x8: RTL and testbench
=================================

Name: tile_fetch_8x8

Overview:
- Upstream feeder of the 8x8 byte tile buffer (MEM32_16 stage).
- Reads one 8x8 tile of bytes from the 16-bit external SRAM, starting at a programmable base address with a programmable line stride.
- Unpacks each 16-bit word into two byte writes, each tagged with row/column indices, for the tile buffer's write port.
- Pulses done when all 64 bytes are written, so the buffer's controller can be started.

Parameters:
- AW, 18, SRAM word-address width.
- DW, 16, SRAM data width; fixed at 16, two bytes per word.
- RD_LAT, 1, SRAM read latency in cycles from sram_ren to valid sram_rdata; legal range 1..4.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to fetch one tile; sampled only in IDLE.
- base_addr  in  AW  word address of tile row 0, word 0; captured on accepted start.
- line_stride  in  AW  word-address distance between tile rows; captured on accepted start.
- sram_addr  out  AW  SRAM read address.
- sram_ren  out  1  SRAM read enable, one cycle per word.
- sram_rdata  in  DW  SRAM read data, valid RD_LAT cycles after sram_ren.
- mem32_enb  out  1  byte write strobe to the tile buffer.
- w_byte  out  8  byte to write.
- out_icounter  out  3  tile row, 0..7.
- out_jcounter  out  3  tile column, 0..7.
- busy  out  1  high while a fetch is in progress.
- done  out  1  one-cycle pulse after the last byte write.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal row/word counters and address registers 0.
- States: IDLE, ISSUE, WAIT, EMIT_HI, EMIT_LO, FIN.
- IDLE:
  - On start=1, capture base_addr and line_stride, set row_addr=base_addr, i=0, w=0, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - sram_ren=1 and sram_addr=row_addr+w, both for exactly one cycle.
  - Next state is WAIT if RD_LAT>1, else EMIT_HI.
- WAIT: hold for RD_LAT-1 cycles, then go to EMIT_HI.
- EMIT_HI:
  - sram_rdata is valid in this cycle (exactly RD_LAT cycles after the ISSUE cycle).
  - Drive mem32_enb=1, w_byte=sram_rdata[15:8], out_icounter=i, out_jcounter=2w.
  - Latch sram_rdata[7:0] into the low-byte register.
- EMIT_LO:
  - Drive mem32_enb=1, w_byte=latched low byte, out_icounter=i, out_jcounter=2w+1.
  - If w<3: w<=w+1, go to ISSUE.
  - Else if i<7: w<=0, i<=i+1, row_addr<=row_addr+line_stride, go to ISSUE.
  - Else go to FIN.
- FIN: done=1 for one cycle, then go to IDLE.
- Byte order: the high byte is the even column. This matches the buffer's {even, odd} read-side packing.
- Timing:
  - Each word takes 2+RD_LAT cycles; a tile takes 32*(2+RD_LAT) cycles plus 1 for FIN.
  - With RD_LAT=1: 97 cycles from the first ISSUE through FIN.
  - The first ISSUE occurs in the cycle after start is accepted.
- busy is 1 in every state except IDLE, including the FIN cycle.
- mem32_enb, sram_ren and done are combinational decodes of state. They are never asserted together.
- Outside their strobe cycles, out_icounter, out_jcounter and w_byte are don't-care; implement them as 0.
- Address arithmetic is modulo 2^AW; wrap-around is silent and allowed.
- start while busy: ignored, not queued. base_addr and line_stride changes mid-fetch have no effect.
- start and done in the same cycle: start is ignored, because FIN is not IDLE.
- reset mid-fetch: in the next cycle return to IDLE with all outputs 0; no done pulse. An SRAM read in flight is discarded.
- line_stride=0 is legal: every row re-reads the same 4 words.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ISSUE, WAIT, EMIT_HI, EMIT_LO, FIN);
  - TILE_DIM=8;
  - WORDS_PER_ROW=4;
  - BYTE_HI/BYTE_LO lane indices.
- One natural sub-module, tile_addr_gen, holds row_addr, i, w and the stride accumulate, with inc_word and inc_row controls. The FSM stays in the top.

Test Plan:
- Basic tile (RD_LAT=1):
  - Stimulus: base=0x00100, stride=0x00040; SRAM word at addr a returns {a[7:0], ~a[7:0]}.
  - Required response: 32 reads at 0x100..0x103, 0x140..0x143, …, 0x2C0..0x2C3; 64 writes with (i,j) covering 0..7 x 0..7 in row-major order, even j = addr[7:0], odd j = inverted; done exactly 97 cycles after the first ISSUE.
- Latency sweep, RD_LAT=3:
  - Required response: read issue spacing of 5 cycles; byte values still correct; total 161 cycles through FIN.
- Address wrap:
  - Stimulus: base=0x3FFFE, stride=0x00002.
  - Required response: row 0 addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; row 1 starts at 0x00000.
- Start while busy:
  - Stimulus: pulse start again at cycle 10, then apply a new base mid-fetch.
  - Required response: no restart, addresses unchanged, exactly one done pulse.
- Reset mid-fetch:
  - Stimulus: assert reset during the EMIT_LO of row 3.
  - Required response: next cycle all outputs 0, no done; a fresh start then completes a full 64-byte fetch.
- Zero stride:
  - Stimulus: line_stride=0.
  - Required response: all 8 rows read the same 4 addresses and write identical byte rows.

Source files
------------

// File: rtl/tile_fetch_8x8_pkg.sv
// Shared types and constants for the 8x8 tile fetcher.
package tile_fetch_8x8_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StEmitHi,
        StEmitLo,
        StFin
    } state_e;

    localparam int unsigned TILE_DIM      = 8;
    localparam int unsigned WORDS_PER_ROW = 4;
    localparam int unsigned BYTE_HI       = 1;
    localparam int unsigned BYTE_LO       = 0;

endpackage

// File: rtl/tile_addr_gen.sv
// Row/word counters and the row base address accumulator for one tile fetch.
module tile_addr_gen
    import tile_fetch_8x8_pkg::*;
#(
    parameter int unsigned AW = 18
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic          i_inc_word,
    input  logic          i_inc_row,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW-1:0] i_line_stride,
    output logic [AW-1:0] o_word_addr,
    output logic [2:0]    o_row_idx,
    output logic [1:0]    o_word_idx,
    output logic          o_last_word,
    output logic          o_last_row
);

    logic [AW-1:0] r_row_addr;
    logic [AW-1:0] r_stride;
    logic [2:0]    r_i;
    logic [1:0]    r_w;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_row_addr <= '0;
            r_stride   <= '0;
            r_i        <= '0;
            r_w        <= '0;
        end else if (i_load) begin
            r_row_addr <= i_base_addr;
            r_stride   <= i_line_stride;
            r_i        <= '0;
            r_w        <= '0;
        end else if (i_inc_word) begin
            r_w <= r_w + 2'd1;
        end else if (i_inc_row) begin
            r_w        <= '0;
            r_i        <= r_i + 3'd1;
            r_row_addr <= r_row_addr + r_stride;
        end
    end

    // Address arithmetic wraps silently modulo 2^AW.
    assign o_word_addr = r_row_addr + AW'(r_w);
    assign o_row_idx   = r_i;
    assign o_word_idx  = r_w;
    assign o_last_word = (r_w == 2'(WORDS_PER_ROW - 1));
    assign o_last_row  = (r_i == 3'(TILE_DIM - 1));

endmodule

// File: rtl/tile_fetch_8x8.sv
// Fetches one 8x8 byte tile from 16-bit SRAM and emits row/column tagged byte writes.
module tile_fetch_8x8
    import tile_fetch_8x8_pkg::*;
#(
    parameter int unsigned AW     = 18,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] line_stride,
    output logic [AW-1:0] sram_addr,
    output logic          sram_ren,
    input  logic [DW-1:0] sram_rdata,
    output logic          mem32_enb,
    output logic [7:0]    w_byte,
    output logic [2:0]    out_icounter,
    output logic [2:0]    out_jcounter,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    state_e        r_state;
    state_e        w_state_next;
    logic [1:0]    r_wait_cnt;
    logic [7:0]    r_lo_byte;
    logic          w_load;
    logic          w_inc_word;
    logic          w_inc_row;
    logic [AW-1:0] w_word_addr;
    logic [2:0]    w_row_idx;
    logic [1:0]    w_word_idx;
    logic          w_last_word;
    logic          w_last_row;

    assign w_load     = (r_state == StIdle) && start;
    assign w_inc_word = (r_state == StEmitLo) && !w_last_word;
    assign w_inc_row  = (r_state == StEmitLo) && w_last_word && !w_last_row;

    tile_addr_gen #(
        .AW(AW)
    ) u_addr_gen (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_load        (w_load),
        .i_inc_word    (w_inc_word),
        .i_inc_row     (w_inc_row),
        .i_base_addr   (base_addr),
        .i_line_stride (line_stride),
        .o_word_addr   (w_word_addr),
        .o_row_idx     (w_row_idx),
        .o_word_idx    (w_word_idx),
        .o_last_word   (w_last_word),
        .o_last_row    (w_last_row)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
            r_lo_byte  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIssue) begin
                r_wait_cnt <= '0;
            end else if (r_state == StWait) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
            // Odd-column byte is consumed one cycle after the read data is valid.
            if (r_state == StEmitHi) begin
                r_lo_byte <= sram_rdata[BYTE_LO*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (start) w_state_next = StIssue;
            StIssue:  w_state_next = (RD_LAT > 1) ? StWait : StEmitHi;
            StWait:   if (r_wait_cnt == WAIT_LAST) w_state_next = StEmitHi;
            StEmitHi: w_state_next = StEmitLo;
            StEmitLo: begin
                if (!w_last_word || !w_last_row) begin
                    w_state_next = StIssue;
                end else begin
                    w_state_next = StFin;
                end
            end
            StFin:    w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        sram_addr    = '0;
        sram_ren     = 1'b0;
        mem32_enb    = 1'b0;
        w_byte       = '0;
        out_icounter = '0;
        out_jcounter = '0;
        done         = 1'b0;
        busy         = (r_state != StIdle);
        unique case (r_state)
            StIssue: begin
                sram_ren  = 1'b1;
                sram_addr = w_word_addr;
            end
            StEmitHi: begin
                mem32_enb    = 1'b1;
                w_byte       = sram_rdata[BYTE_HI*8 +: 8];
                out_icounter = w_row_idx;
                out_jcounter = {w_word_idx, 1'b0};
            end
            StEmitLo: begin
                mem32_enb    = 1'b1;
                w_byte       = r_lo_byte;
                out_icounter = w_row_idx;
                out_jcounter = {w_word_idx, 1'b1};
            end
            StFin:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tile_fetch_8x8.sv
// Randomized bench for tile_fetch_8x8 at read latencies 1 and 3 against a tile-level model.
module tb_tile_fetch_8x8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_in;
    logic [17:0] base_in;
    logic [17:0] stride_in;
    logic        sel;
    logic [7:0]  key;

    logic [17:0] addr1, addr3;
    logic        ren1, ren3, enb1, enb3, busy1, busy3, done1, done3;
    logic [7:0]  byte1, byte3;
    logic [2:0]  i1, i3, j1, j3;
    logic [15:0] p1;
    logic [15:0] p3 [3];

    logic [17:0] o_addr;
    logic        o_ren, o_enb, o_busy, o_done;
    logic [7:0]  o_byte;
    logic [2:0]  o_i, o_j;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    tile_fetch_8x8 #(.AW(18), .DW(16), .RD_LAT(1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .start        (start_in & ~sel),
        .base_addr    (base_in),
        .line_stride  (stride_in),
        .sram_addr    (addr1),
        .sram_ren     (ren1),
        .sram_rdata   (p1),
        .mem32_enb    (enb1),
        .w_byte       (byte1),
        .out_icounter (i1),
        .out_jcounter (j1),
        .busy         (busy1),
        .done         (done1)
    );

    tile_fetch_8x8 #(.AW(18), .DW(16), .RD_LAT(3)) dut3 (
        .clock        (clock),
        .reset        (reset),
        .start        (start_in & sel),
        .base_addr    (base_in),
        .line_stride  (stride_in),
        .sram_addr    (addr3),
        .sram_ren     (ren3),
        .sram_rdata   (p3[2]),
        .mem32_enb    (enb3),
        .w_byte       (byte3),
        .out_icounter (i3),
        .out_jcounter (j3),
        .busy         (busy3),
        .done         (done3)
    );

    assign o_addr = sel ? addr3 : addr1;
    assign o_ren  = sel ? ren3  : ren1;
    assign o_enb  = sel ? enb3  : enb1;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_byte = sel ? byte3 : byte1;
    assign o_i    = sel ? i3    : i1;
    assign o_j    = sel ? j3    : j1;

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        mem_word = {a[7:0] ^ key, ~a[7:0]};
    endfunction

    // SRAM models: data appears exactly RD_LAT cycles after the read enable, garbage otherwise.
    always @(posedge clock) begin
        p1    <= ren1 ? mem_word(addr1) : 16'hDEAD;
        p3[0] <= ren3 ? mem_word(addr3) : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic use3, input logic [17:0] base, input logic [17:0] stride,
                         input logic poke, input string tag);
        logic [31:0] rd_q[$];
        logic [31:0] wr_q[$];
        int          lat;
        int          done_c;
        int          n_done;
        int          n_excl;
        int          n_busy_bad;
        logic        exp_busy;
        logic [17:0] a;
        logic [15:0] wd;
        logic [7:0]  b;
        int          cyc;
        lat        = use3 ? 3 : 1;
        done_c     = -1;
        n_done     = 0;
        n_excl     = 0;
        n_busy_bad = 0;
        sel        = use3;
        @(negedge clock);
        start_in  = 1'b1;
        base_in   = base;
        stride_in = stride;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (c == 0) start_in = 1'b0;
            if (o_ren) rd_q.push_back(32'({12'(c), o_addr}));
            if (o_enb) wr_q.push_back(32'({12'(c), o_i, o_j, o_byte}));
            if (int'(o_ren) + int'(o_enb) + int'(o_done) > 1) n_excl++;
            if (o_done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            exp_busy = (done_c < 0) || (c == done_c);
            if (o_busy !== exp_busy) n_busy_bad++;
            if (poke && c == 10) begin
                start_in  = 1'b1;
                base_in   = ~base;
                stride_in = stride + 18'd5;
            end
            if (poke && c == 11) start_in = 1'b0;
            if (done_c >= 0 && c >= done_c + 4) break;
        end
        check($sformatf("%s/ndone", tag), n_done, 1);
        check($sformatf("%s/done_cyc", tag), done_c, 32 * (2 + lat));
        check($sformatf("%s/excl", tag), n_excl, 0);
        check($sformatf("%s/busy", tag), n_busy_bad, 0);
        check($sformatf("%s/nrd", tag), rd_q.size(), 32);
        check($sformatf("%s/nwr", tag), wr_q.size(), 64);
        for (int k = 0; k < 32 && k < rd_q.size(); k++) begin
            a = base + 18'(k / 4) * stride + 18'(k % 4);
            check($sformatf("%s/rd%0d", tag, k), rd_q[k], 32'({12'(k * (2 + lat)), a}));
        end
        for (int k = 0; k < 64 && k < wr_q.size(); k++) begin
            a   = base + 18'(k / 8) * stride + 18'((k % 8) / 2);
            wd  = mem_word(a);
            b   = (k % 2 == 0) ? wd[15:8] : wd[7:0];
            cyc = (k / 2) * (2 + lat) + lat + (k % 2);
            check($sformatf("%s/wr%0d", tag, k), wr_q[k],
                  32'({12'(cyc), 3'(k / 8), 3'(k % 8), b}));
        end
    endtask

    task automatic reset_mid();
        logic found;
        int   n_done;
        found  = 1'b0;
        n_done = 0;
        sel    = 1'b0;
        @(negedge clock);
        start_in  = 1'b1;
        base_in   = 18'($urandom);
        stride_in = 18'($urandom);
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (c == 0) start_in = 1'b0;
            if (enb1 && i1 == 3'd3 && j1 == 3'd3) begin
                found = 1'b1;
                reset = 1'b1;
                break;
            end
        end
        check("rmid/found", 32'(found), 1);
        @(negedge clock);
        check("rmid/ctl", {ren1, enb1, done1, busy1}, 0);
        check("rmid/addr", 32'(addr1), 0);
        check("rmid/data", {byte1, i1, j1}, 0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done1 || busy1) n_done++;
        end
        check("rmid/quiet", n_done, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start_in  = 1'b0;
        base_in   = '0;
        stride_in = '0;
        sel       = 1'b0;
        key       = 8'h00;
        repeat (4) @(negedge clock);
        check("rst1/ctl", {ren1, enb1, done1, busy1}, 0);
        check("rst1/addr", 32'(addr1), 0);
        check("rst1/data", {byte1, i1, j1}, 0);
        check("rst3/ctl", {ren3, enb3, done3, busy3}, 0);
        check("rst3/addr", 32'(addr3), 0);
        check("rst3/data", {byte3, i3, j3}, 0);
        reset = 1'b0;

        fetch(1'b0, 18'h00100, 18'h00040, 1'b0, "basic");
        fetch(1'b1, 18'h00100, 18'h00040, 1'b0, "lat3");
        key = 8'($urandom);
        fetch(1'b0, 18'h3FFFE, 18'h00002, 1'b0, "wrap");
        fetch(1'b0, 18'($urandom), 18'($urandom), 1'b1, "poke");
        reset_mid();
        fetch(1'b0, 18'($urandom), 18'($urandom), 1'b0, "after_rst");
        fetch(1'b0, 18'($urandom), 18'h0, 1'b0, "zstride1");
        fetch(1'b1, 18'($urandom), 18'h0, 1'b0, "zstride3");
        for (int r = 0; r < 3; r++) begin
            key = 8'($urandom);
            fetch(1'b0, 18'($urandom), 18'($urandom), 1'b0, $sformatf("rnd1_%0d", r));
            fetch(1'b1, 18'($urandom), 18'($urandom), 1'b0, $sformatf("rnd3_%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
